clk_sel_ctrl: RTL and testbench



---
 rtl/clk_sel_ctrl_pkg.sv | 22 ++
 rtl/clk_sel_ctrl_if.sv | 30 +++
 rtl/clk_sel_ctrl.sv | 108 ++++++++++
 tb/tb_clk_sel_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_sel_ctrl_pkg.sv
// Shared clocking types for the clock polarity select sequencer.
// Holds the state encoding, the polarity constants and the counter sizing helper.
package clk_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        SETTLE,
        ACK_ONLY
    } clk_sel_state_t;

    localparam logic POL_NORMAL   = 1'b0;
    localparam logic POL_INVERTED = 1'b1;

    // Width of a down-counter that must hold the larger of the two hold times.
    function automatic int cnt_width(input int gate_cycles, input int settle_cycles);
        int hi;
        hi = (gate_cycles > settle_cycles) ? gate_cycles : settle_cycles;
        return $clog2(hi + 1);
    endfunction

endpackage

// File: rtl/clk_sel_ctrl_if.sv
// Request/acknowledge and status bundle between a polarity requester and clk_sel_ctrl.
// The requester drives req/req_sel; the sequencer drives select, gate and status.
interface clk_sel_ctrl_if;

    logic req;
    logic req_sel;
    logic sel_out;
    logic gate_en;
    logic busy;
    logic ack;

    modport master (
        output req,
        output req_sel,
        input  sel_out,
        input  gate_en,
        input  busy,
        input  ack
    );

    modport slave (
        input  req,
        input  req_sel,
        output sel_out,
        output gate_en,
        output busy,
        output ack
    );

endinterface

// File: rtl/clk_sel_ctrl.sv
// Sequences clock polarity switches with the gate closed around the sel change; ack after GATE+SETTLE cycles (1 cycle if no change).
// No backpressure: requests are only sampled in IDLE and are dropped while a switch is in progress.
module clk_sel_ctrl
    import clk_sel_ctrl_pkg::*;
#(
    parameter int GATE_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic          clk_in,
    input  logic          rst_n,
    clk_sel_ctrl_if.slave ctrl
);

    localparam int CNT_W = cnt_width(GATE_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    if (GATE_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_param_check
        $fatal(1, "clk_sel_ctrl: GATE_CYCLES and SETTLE_CYCLES must both be 1 or more");
    end

    clk_sel_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pol_q, pol_d;
    logic             sel_q, sel_d;
    logic             gate_q, gate_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pol_q   <= POL_NORMAL;
            sel_q   <= POL_NORMAL;
            gate_q  <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pol_q   <= pol_d;
            sel_q   <= sel_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    // Every output is computed here as a next value and only leaves through a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pol_d   = pol_q;
        sel_d   = sel_q;
        gate_d  = gate_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ctrl.req) begin
                    if (ctrl.req_sel != sel_q) begin
                        pol_d   = ctrl.req_sel;
                        state_d = GATE;
                        gate_d  = 1'b0;
                        busy_d  = 1'b1;
                        cnt_d   = GATE_LOAD;
                    end else begin
                        state_d = ACK_ONLY;
                        ack_d   = 1'b1;
                    end
                end
            end
            GATE: begin
                if (cnt_q == '0) begin
                    sel_d   = pol_q;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    gate_d  = 1'b1;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK_ONLY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ctrl.sel_out = sel_q;
    assign ctrl.gate_en = gate_q;
    assign ctrl.busy    = busy_q;
    assign ctrl.ack     = ack_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Bench for clk_sel_ctrl: a default instance and a GATE=1/SETTLE=5 instance share one stimulus stream,
// a timeline model predicts levels and acks, and a monitor compares on every falling edge.
module tb_clk_sel_ctrl;
    import clk_sel_ctrl_pkg::*;

    localparam int G0 = 2;
    localparam int S0 = 2;
    localparam int G1 = 1;
    localparam int S1 = 5;

    typedef struct {
        int   cyc;
        logic sel;
    } exp_t;

    logic clk;
    logic rst_n;
    logic req;
    logic req_sel;
    logic done;
    logic timeout_hit;

    clk_sel_ctrl_if if0 ();
    clk_sel_ctrl_if if1 ();

    assign if0.req     = req;
    assign if0.req_sel = req_sel;
    assign if1.req     = req;
    assign if1.req_sel = req_sel;

    clk_sel_ctrl #(.GATE_CYCLES(G0), .SETTLE_CYCLES(S0)) dut0 (
        .clk_in (clk),
        .rst_n  (rst_n),
        .ctrl   (if0)
    );

    clk_sel_ctrl #(.GATE_CYCLES(G1), .SETTLE_CYCLES(S1)) dut1 (
        .clk_in (clk),
        .rst_n  (rst_n),
        .ctrl   (if1)
    );

    logic o_sel [2];
    logic o_gate[2];
    logic o_busy[2];
    logic o_ack [2];

    assign o_sel[0]  = if0.sel_out;
    assign o_gate[0] = if0.gate_en;
    assign o_busy[0] = if0.busy;
    assign o_ack[0]  = if0.ack;
    assign o_sel[1]  = if1.sel_out;
    assign o_gate[1] = if1.gate_en;
    assign o_busy[1] = if1.busy;
    assign o_ack[1]  = if1.ack;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    int   cyc;
    int   start  [2];
    int   free_at[2];
    logic old_sel[2];
    logic cur_sel[2];
    exp_t q0[$];
    exp_t q1[$];

    function automatic int gc(input int i);
        return (i == 0) ? G0 : G1;
    endfunction

    function automatic int sc(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    function automatic void qpush(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic int qfront_cyc(input int i);
        return (i == 0) ? q0[0].cyc : q1[0].cyc;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            start[i]   = -1;
            free_at[i] = 0;
            old_sel[i] = POL_NORMAL;
            cur_sel[i] = POL_NORMAL;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Expected levels after edge c: closed for G+S cycles from the accepting edge, sel flips G edges in.
    function automatic void expect_lvl(input int i, input int c,
                                       output logic s, output logic g, output logic b);
        if (start[i] >= 0 && (c - start[i]) < gc(i) + sc(i)) begin
            g = 1'b0;
            b = 1'b1;
            s = ((c - start[i]) >= gc(i)) ? cur_sel[i] : old_sel[i];
        end else begin
            g = 1'b1;
            b = 1'b0;
            s = cur_sel[i];
        end
    endfunction

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                for (int i = 0; i < 2; i++) begin
                    if (req && cyc >= free_at[i]) begin
                        if (req_sel != cur_sel[i]) begin
                            old_sel[i] = cur_sel[i];
                            cur_sel[i] = req_sel;
                            start[i]   = cyc;
                            free_at[i] = cyc + gc(i) + sc(i) + 1;
                            qpush(i, '{cyc: cyc + gc(i) + sc(i), sel: req_sel});
                        end else begin
                            free_at[i] = cyc + 2;
                            qpush(i, '{cyc: cyc, sel: cur_sel[i]});
                        end
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int n_cmp;
    int n_err;

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, i, cyc, act, exp);
        end
    endtask

    initial begin
        logic es, eg, eb;
        logic prev_sel[2];
        exp_t e;
        n_cmp = 0;
        n_err = 0;
        prev_sel[0] = 1'b0;
        prev_sel[1] = 1'b0;
        while (!done) begin
            @(negedge clk or negedge rst_n);
            #1;
            for (int i = 0; i < 2; i++) begin
                expect_lvl(i, cyc, es, eg, eb);
                chk("sel_out", i, int'(o_sel[i]), int'(es));
                chk("gate_en", i, int'(o_gate[i]), int'(eg));
                chk("busy", i, int'(o_busy[i]), int'(eb));
                if (rst_n && o_sel[i] != prev_sel[i])
                    chk("sel_change_gate_open", i, int'(o_gate[i]), 0);
                prev_sel[i] = o_sel[i];
                if (o_ack[i]) begin
                    if (qsize(i) == 0) begin
                        chk("ack_spurious", i, int'(o_ack[i]), 0);
                    end else begin
                        e = qpop(i);
                        chk("ack_cycle", i, cyc, e.cyc);
                        chk("ack_sel", i, int'(o_sel[i]), int'(e.sel));
                    end
                end else if (qsize(i) != 0 && qfront_cyc(i) <= cyc) begin
                    e = qpop(i);
                    chk("ack_missing", i, int'(o_ack[i]), 1);
                end
            end
        end
        for (int i = 0; i < 2; i++)
            chk("ack_queue_drained", i, qsize(i), 0);
        chk("ack_wait_timeout", 0, int'(timeout_hit), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input logic s);
        req     = 1'b1;
        req_sel = s;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic reset_mid_cycle();
        req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        done        = 1'b0;
        timeout_hit = 1'b0;
        req         = 1'b0;
        req_sel     = POL_NORMAL;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        pulse(POL_INVERTED);
        repeat (8) @(negedge clk);

        pulse(POL_INVERTED);
        repeat (4) @(negedge clk);

        // Switch back to normal, then poke the inputs while the gate is closed.
        req = 1'b1; req_sel = POL_NORMAL;
        @(negedge clk);
        req = 1'b1; req_sel = POL_INVERTED;
        @(negedge clk);
        req = 1'b0; req_sel = POL_NORMAL;
        @(negedge clk);
        req_sel = POL_INVERTED;
        n = 0;
        while (!if0.ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout_hit = 1'b1;
        pulse(POL_INVERTED);
        repeat (10) @(negedge clk);

        // Abort a 0->1 switch while the default instance is settling.
        pulse(POL_NORMAL);
        repeat (8) @(negedge clk);
        pulse(POL_INVERTED);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_mid_cycle();
            end else begin
                req     = ($urandom_range(0, 2) == 0);
                req_sel = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        req = 1'b0;
        repeat (12) @(negedge clk);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "bench did not terminate");
    end

endmodule
